// File: rtl/seg7_scan_driver.sv
// seg7_scan_driver: multiplexed seven-segment driver with an all-off blanking slot between digits.
// Define SEG7_BCD_MODE_EN to convert each load to decimal with a sequential double-dabble converter.
module seg7_scan_driver #(
   parameter int NUM_DIGITS   = 2,
   parameter int DATA_W       = 8,
   parameter int REFRESH_DIV  = 50000,
   parameter int BLANK_CYCLES = 500,
   parameter bit ACTIVE_LOW   = 1'b1
) (
   input  logic                  clk,
   input  logic                  n_rst,
   input  logic                  load_valid,
   output logic                  load_ready,
   input  logic [DATA_W-1:0]     load_data,
   input  logic [NUM_DIGITS-1:0] dp_in,
   output logic [6:0]            seg,
   output logic [NUM_DIGITS-1:0] digit_en,
   output logic                  dp
);
   localparam int DISP_W = 4 * NUM_DIGITS;
   localparam int IDX_W = NUM_DIGITS > 1 ? $clog2(NUM_DIGITS) : 1;
   localparam int CNT_MAX = REFRESH_DIV > BLANK_CYCLES ? REFRESH_DIV : BLANK_CYCLES;
   localparam int CNT_W = CNT_MAX > 1 ? $clog2(CNT_MAX) : 1;
   localparam logic [0:0] SHOW = 1'b0;
   localparam logic [0:0] BLANK = 1'b1;
   logic [0:0] state;
   logic [IDX_W-1:0] idx, idx_nxt;
   logic [CNT_W-1:0] cnt;
   logic show_end, blank_end;
   logic [DISP_W-1:0] disp_q;
   logic [NUM_DIGITS-1:0] dp_q;
   logic lit;
   logic [3:0] nib;
   logic [6:0] seg_h, seg_a;
   logic [NUM_DIGITS-1:0] en_a;
   logic dp_a;

   function automatic logic [6:0] decode(input logic [3:0] v);
      case (v)
         4'h0: decode = 7'b1111110;
         4'h1: decode = 7'b0110000;
         4'h2: decode = 7'b1101101;
         4'h3: decode = 7'b1111001;
         4'h4: decode = 7'b0110011;
         4'h5: decode = 7'b1011011;
         4'h6: decode = 7'b1011111;
         4'h7: decode = 7'b1110000;
         4'h8: decode = 7'b1111111;
         4'h9: decode = 7'b1111011;
         4'hA: decode = 7'b1110111;
         4'hB: decode = 7'b0011111;
         4'hC: decode = 7'b1001110;
         4'hD: decode = 7'b0111101;
         4'hE: decode = 7'b1001111;
         default: decode = 7'b1000111;
      endcase
   endfunction

   assign idx_nxt = idx == IDX_W'(NUM_DIGITS - 1) ? '0 : idx + 1'b1;
   assign show_end = state == SHOW && cnt == CNT_W'(REFRESH_DIV - 1);
   assign blank_end = state == BLANK && cnt == CNT_W'(BLANK_CYCLES - 1);

   // Scan timing free-runs; loads never restart it.
   always_ff @(posedge clk or negedge n_rst)
      if (!n_rst) begin
         state <= SHOW;
         idx <= '0;
         cnt <= '0;
      end else if (show_end || blank_end) begin
         cnt <= '0;
         state <= (show_end && BLANK_CYCLES != 0) ? BLANK : SHOW;
         idx <= (blank_end || BLANK_CYCLES == 0) ? idx_nxt : idx;
      end else
         cnt <= cnt + 1'b1;

`ifdef SEG7_BCD_MODE_EN
   localparam int BIT_W = $clog2(DATA_W + 1);
   logic busy;
   logic [BIT_W-1:0] bit_cnt;
   logic [DATA_W-1:0] bin_q;
   logic [DISP_W-1:0] bcd_q, bcd_adj;
   logic [NUM_DIGITS-1:0] dp_pend;

   // Carries out of the top BCD digit are dropped, giving value mod 10^NUM_DIGITS.
   always_comb begin
      bcd_adj = bcd_q;
      for (int i = 0; i < NUM_DIGITS; i++)
         bcd_adj[4*i+:4] = bcd_q[4*i+:4] > 4'd4 ? bcd_q[4*i+:4] + 4'd3 : bcd_q[4*i+:4];
   end

   assign load_ready = !busy;

   always_ff @(posedge clk or negedge n_rst)
      if (!n_rst) begin
         busy <= 1'b0;
         bit_cnt <= '0;
         bin_q <= '0;
         bcd_q <= '0;
         dp_pend <= '0;
         disp_q <= '0;
         dp_q <= '0;
      end else if (load_valid && load_ready) begin
         busy <= 1'b1;
         bit_cnt <= '0;
         bin_q <= load_data;
         bcd_q <= '0;
         dp_pend <= dp_in;
      end else if (busy) begin
         if (bit_cnt == BIT_W'(DATA_W)) begin
            busy <= 1'b0;
            disp_q <= bcd_q;
            dp_q <= dp_pend;
         end else begin
            bit_cnt <= bit_cnt + 1'b1;
            bin_q <= bin_q << 1;
            bcd_q <= {bcd_adj[DISP_W-2:0], bin_q[DATA_W-1]};
         end
      end
`else
   localparam int EXT_W = DATA_W > DISP_W ? DATA_W : DISP_W;
   logic [EXT_W-1:0] load_ext;

   assign load_ext = EXT_W'(load_data);
   assign load_ready = 1'b1;

   always_ff @(posedge clk or negedge n_rst)
      if (!n_rst) begin
         disp_q <= '0;
         dp_q <= '0;
      end else if (load_valid && load_ready) begin
         disp_q <= load_ext[DISP_W-1:0];
         dp_q <= dp_in;
      end
`endif

   // Gating with n_rst forces the inactive level for the whole reset pulse.
   assign lit = n_rst && state == SHOW;
   assign nib = disp_q[4*idx+:4];
   assign seg_h = decode(nib);
   assign seg_a = lit ? seg_h : 7'b0;
   assign en_a = lit ? NUM_DIGITS'(1) << idx : '0;
   assign dp_a = lit && dp_q[idx];
   assign seg = ACTIVE_LOW ? ~seg_a : seg_a;
   assign digit_en = ACTIVE_LOW ? ~en_a : en_a;
   assign dp = ACTIVE_LOW ? ~dp_a : dp_a;
endmodule
